sha1_pad: RTL and testbench
===========================

SHA1_PAD -- requirements
Module: sha1_pad

Interface
REQ-001 SHALL have parameter none; block size fixed at 16 x 32-bit words, default n/a.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 msg_vld  input  1  message word valid.
REQ-005 msg_data  input  32  message word, big-endian (first byte in [31:24]).
REQ-006 msg_last  input  1  final word of message.
REQ-007 msg_nbytes  input  3  valid bytes in final word, 0..4; ignored unless msg_last; values 5..7 treated as 4.
REQ-008 msg_rdy  output  1  word accepted when msg_vld & msg_rdy.
REQ-009 core_dout_vld  input  1  1T done pulse from downstream SHA-1 core.
REQ-010 blk_vld  output  1  drives core din_vld; high exactly 16 consecutive cycles per block.
REQ-011 blk_data  output  32  drives core din; word 0 first.
REQ-012 use_prec_cv  output  1  0 on first block of a message, 1 on later blocks; stable while blk_vld.
REQ-013 pad_busy  output  1  high from first accepted word until core_dout_vld of the message's last block.

Function
REQ-014 States: FILL, SEND, WAIT, PAD, LEN; reset state FILL.
REQ-015 FILL: msg_rdy=1; each accepted word written to buffer[wptr], wptr++ (4-bit, wraps 15->0); byte counter += 4 (or msg_nbytes on last).
REQ-016 FILL, non-last word written at wptr=15 -> SEND next cycle; msg_rdy=0 outside FILL.
REQ-017 Last word with n=msg_nbytes<4: stored word keeps top n bytes, byte n = 0x80, lower bytes 0; with n=4: word stored unchanged, next index gets 0x80000000; n=0: word replaced by 0x80000000.
REQ-018 After last word go to PAD: zero-fill indices up to 13 (one word per cycle), then LEN writes index 14 = length[63:32], index 15 = length[31:0], length = bytes*8 modulo 2^64.
REQ-019 If the 0x80 word lands at index 14 or 15, PAD zero-fills to 15, block sent, then a second block of words 0..13 = 0 plus length words is built and sent.
REQ-020 SEND: blk_vld=1 for 16 cycles, blk_data=buffer[0..15] in order, then WAIT; blk_vld SHALL be low at least 1 cycle between blocks.
REQ-021 WAIT: hold until core_dout_vld=1; then FILL (more message data) or, after final block, FILL with byte counter cleared and use_prec_cv cleared.
REQ-022 Latency: blk_vld rises the cycle after the buffer is complete (16th word or final length word written).
REQ-023 msg_vld in any state other than FILL is not accepted; data SHALL be held by the source.
REQ-024 core_dout_vld outside WAIT is ignored.
REQ-025 use_prec_cv SHALL be 1 for every block after the first in a message, including the extra pad block.

Reset
REQ-026 On rst_n low, asynchronously: state=FILL, wptr=0, byte counter=0, msg_rdy=0, blk_vld=0, blk_data=0, use_prec_cv=0, pad_busy=0.
REQ-027 msg_rdy rises the first cycle after rst_n deasserts; reset mid-SEND aborts the block with no further blk_vld.
REQ-028 Buffer contents need no reset.

Structure
REQ-029 Shared package sha1_pkg holds state enum, PAD_WORD 32'h80000000, BLK_WORDS=16, H0..H4 init constants.
REQ-030 One sub-module sha1_blk_buf: 16x32 register file, write port (index, data), read port (index); controller and counters stay in sha1_pad.

Verification
REQ-031 "abc" (one word 0x61626300, nbytes=3, last) -> one block: w0=0x61626380, w1..w14=0, w15=0x00000018; core dout a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
REQ-032 Empty message (nbytes=0, last) -> w0=0x80000000, w15=0; core dout da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
REQ-033 56-byte "abcdbcdecdef...nopq" -> two blocks, block 2 w0..w13=0, w15=0x1C0, use_prec_cv=1; dout 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
REQ-034 64-byte message -> second block w0=0x80000000, w15=0x200; blk_vld low >=1 cycle between blocks.
REQ-035 msg_vld held high during SEND/WAIT -> msg_rdy=0, no words lost or duplicated; reset asserted mid-SEND -> blk_vld=0 immediately, next message restarts with use_prec_cv=0.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message padder and its block buffer.
package sha1_pkg;

   localparam int          BLK_WORDS = 16;
   localparam logic [31:0] PAD_WORD  = 32'h8000_0000;

   // Initial chaining value consumed by the downstream core on a message's first block.
   localparam logic [31:0] H0 = 32'h6745_2301;
   localparam logic [31:0] H1 = 32'hEFCD_AB89;
   localparam logic [31:0] H2 = 32'h98BA_DCFE;
   localparam logic [31:0] H3 = 32'h1032_5476;
   localparam logic [31:0] H4 = 32'hC3D2_E1F0;

   typedef enum logic [2:0] {
      FILL = 3'd0,
      SEND = 3'd1,
      WAIT = 3'd2,
      PAD  = 3'd3,
      LEN  = 3'd4
   } pad_state_t;

   // Final message word with n (0..4) valid bytes: keep the top n bytes and
   // append the 0x80 marker right after them.
   function automatic logic [31:0] pad_last_word(input logic [31:0] w, input logic [2:0] n);
      logic [31:0] r;
      case (n)
         3'd0:    r = PAD_WORD;
         3'd1:    r = {w[31:24], 8'h80, 16'h0000};
         3'd2:    r = {w[31:16], 8'h80, 8'h00};
         3'd3:    r = {w[31:8], 8'h80};
         default: r = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sha1_pad_if.sv
// Message-in / block-out bundle between the padder, its message source and the SHA-1 core.
interface sha1_pad_if;

   // A message word transfers on a rising edge where msg_vld & msg_rdy are both high;
   // the source holds msg_data/msg_last/msg_nbytes stable while msg_vld is high and
   // msg_rdy is low. blk_vld has no back-pressure: the core takes one word per cycle.
   logic        msg_vld;
   logic [31:0] msg_data;
   logic        msg_last;
   logic [2:0]  msg_nbytes;
   logic        msg_rdy;
   logic        core_dout_vld;
   logic        blk_vld;
   logic [31:0] blk_data;
   logic        use_prec_cv;
   logic        pad_busy;

   modport master (
      output msg_vld, msg_data, msg_last, msg_nbytes, core_dout_vld,
      input  msg_rdy, blk_vld, blk_data, use_prec_cv, pad_busy
   );

   modport slave (
      input  msg_vld, msg_data, msg_last, msg_nbytes, core_dout_vld,
      output msg_rdy, blk_vld, blk_data, use_prec_cv, pad_busy
   );

endinterface

// File: rtl/sha1_blk_buf.sv
// 16 x 32-bit block register file: one synchronous write port, one combinational read port.
module sha1_blk_buf
   import sha1_pkg::*;
(
   input  logic        clk,
   input  logic        wr_en,
   input  logic [3:0]  wr_idx,
   input  logic [31:0] wr_data,
   input  logic [3:0]  rd_idx,
   output logic [31:0] rd_data
);

   logic [31:0] mem [BLK_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs message words into 512-bit blocks, appends the 0x80
// marker, zero fill and 64-bit bit length, and streams each block to the core.
module sha1_pad
   import sha1_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   sha1_pad_if.slave  bus,
   output pad_state_t state_dbg
);

   pad_state_t  state;
   logic [3:0]  wptr;
   logic [3:0]  snd_idx;
   logic [60:0] byte_cnt;
   logic        msg_done;
   logic        len_done;
   logic        pend_80;
   logic        rdy_q;
   logic        blk_vld_q;
   logic [31:0] blk_data_q;
   logic        prec_q;
   logic        busy_q;

   logic        accept;
   logic [2:0]  nb;
   logic        to_send;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [3:0]  rd_idx;
   logic [31:0] rd_data;

   assign accept = bus.msg_vld & rdy_q;
   assign nb     = (bus.msg_nbytes > 3'd4) ? 3'd4 : bus.msg_nbytes;
   assign rd_idx = (state == SEND) ? snd_idx : 4'd0;

   // Every path that writes index 15 completes the block.
   assign to_send = (wptr == 4'd15) &&
                    (((state == FILL) && accept) || (state == PAD) || (state == LEN));

   always_comb begin
      wr_en   = 1'b0;
      wr_data = 32'h0;
      case (state)
         FILL: begin
            wr_en   = accept;
            wr_data = bus.msg_last ? pad_last_word(bus.msg_data, nb) : bus.msg_data;
         end
         PAD: begin
            wr_en   = 1'b1;
            wr_data = pend_80 ? PAD_WORD : 32'h0;
         end
         LEN: begin
            wr_en   = 1'b1;
            wr_data = wptr[0] ? {byte_cnt[28:0], 3'b000} : byte_cnt[60:29];
         end
         default: begin
            wr_en   = 1'b0;
            wr_data = 32'h0;
         end
      endcase
   end

   sha1_blk_buf u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (wptr),
      .wr_data (wr_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         wptr       <= 4'd0;
         snd_idx    <= 4'd0;
         byte_cnt   <= 61'd0;
         msg_done   <= 1'b0;
         len_done   <= 1'b0;
         pend_80    <= 1'b0;
         rdy_q      <= 1'b0;
         blk_vld_q  <= 1'b0;
         blk_data_q <= 32'h0;
         prec_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               rdy_q <= 1'b1;
               if (accept) begin
                  wptr     <= wptr + 4'd1;
                  busy_q   <= 1'b1;
                  byte_cnt <= byte_cnt + (bus.msg_last ? 61'(nb) : 61'd4);
                  if (bus.msg_last) begin
                     msg_done <= 1'b1;
                     // A full final word leaves the marker for the next free slot.
                     pend_80  <= (nb == 3'd4);
                     if (wptr != 4'd15) begin
                        rdy_q <= 1'b0;
                        state <= ((wptr == 4'd13) && (nb != 3'd4)) ? LEN : PAD;
                     end
                  end
               end
            end
            PAD: begin
               pend_80 <= 1'b0;
               wptr    <= wptr + 4'd1;
               if (wptr == 4'd13) begin
                  state <= LEN;
               end
            end
            LEN: begin
               wptr <= wptr + 4'd1;
               if (wptr == 4'd15) begin
                  len_done <= 1'b1;
               end
            end
            SEND: begin
               if (snd_idx == 4'd0) begin
                  blk_vld_q  <= 1'b0;
                  blk_data_q <= 32'h0;
                  state      <= WAIT;
               end else begin
                  blk_data_q <= rd_data;
                  snd_idx    <= snd_idx + 4'd1;
               end
            end
            WAIT: begin
               if (bus.core_dout_vld) begin
                  if (len_done) begin
                     state    <= FILL;
                     rdy_q    <= 1'b1;
                     byte_cnt <= 61'd0;
                     prec_q   <= 1'b0;
                     busy_q   <= 1'b0;
                     msg_done <= 1'b0;
                     len_done <= 1'b0;
                     pend_80  <= 1'b0;
                  end else if (msg_done) begin
                     state  <= PAD;
                     prec_q <= 1'b1;
                  end else begin
                     state  <= FILL;
                     rdy_q  <= 1'b1;
                     prec_q <= 1'b1;
                  end
               end
            end
            default: begin
               state <= FILL;
            end
         endcase

         // Word 0 is presented on the first SEND cycle, so it is fetched here.
         if (to_send) begin
            state      <= SEND;
            rdy_q      <= 1'b0;
            blk_vld_q  <= 1'b1;
            blk_data_q <= rd_data;
            snd_idx    <= 4'd1;
         end
      end
   end

   assign bus.msg_rdy     = rdy_q;
   assign bus.blk_vld     = blk_vld_q;
   assign bus.blk_data    = blk_data_q;
   assign bus.use_prec_cv = prec_q;
   assign bus.pad_busy    = busy_q;
   assign state_dbg       = state;

endmodule

// File: tb/tb_sha1_pad.sv
// Directed bench for sha1_pad: drives messages, plays the SHA-1 core's done pulse,
// and checks every emitted block word against hand-computed padding.
module tb_sha1_pad;
   import sha1_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   pad_state_t state_dbg;

   sha1_pad_if bus();

   sha1_pad dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int run_len = 0;
   int cd_cnt = 0;
   int stall_cycles = 0;

   logic [31:0] got_q[$];
   logic        prec_q[$];
   int          blen_q[$];
   logic [31:0] exp_q[$];
   logic        exp_prec_q[$];
   logic [31:0] msg_q[$];

   function automatic logic [31:0] pat(input int i);
      return 32'(i) * 32'h0404_0404 + 32'h0001_0203;
   endfunction

   // Block capture plus core model: done pulse 3 cycles after a complete 16-word block.
   initial begin
      bus.core_dout_vld = 1'b0;
      forever begin
         @(negedge clk);
         bus.core_dout_vld = 1'b0;
         if (!rst_n) begin
            run_len = 0;
            cd_cnt  = 0;
         end else begin
            if (cd_cnt != 0) begin
               cd_cnt--;
               if (cd_cnt == 0) bus.core_dout_vld = 1'b1;
            end
            if (bus.blk_vld) begin
               got_q.push_back(bus.blk_data);
               prec_q.push_back(bus.use_prec_cv);
               run_len++;
            end else if (run_len != 0) begin
               blen_q.push_back(run_len);
               if (run_len == 16) cd_cnt = 3;
               run_len = 0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic clear_capture();
      got_q.delete();
      prec_q.delete();
      blen_q.delete();
      exp_q.delete();
      exp_prec_q.delete();
   endtask

   task automatic send_words(input logic [2:0] nb_last, input bit with_last);
      int t;
      for (int i = 0; i < msg_q.size(); i++) begin
         bus.msg_vld    = 1'b1;
         bus.msg_data   = msg_q[i];
         bus.msg_last   = with_last && (i == msg_q.size() - 1);
         bus.msg_nbytes = bus.msg_last ? nb_last : 3'd0;
         t = 0;
         while (!bus.msg_rdy && t < 2000) begin
            @(negedge clk);
            t++;
            stall_cycles++;
         end
         if (t >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout word %0d: msg_rdy=%0b required 1", i, bus.msg_rdy);
            break;
         end
         @(negedge clk);
      end
      bus.msg_vld  = 1'b0;
      bus.msg_last = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (bus.pad_busy && t < 1000) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (bus.pad_busy !== 1'b0 || bus.msg_rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL %s_idle: pad_busy=%0b msg_rdy=%0b required 0/1", name, bus.pad_busy, bus.msg_rdy);
      end
   endtask

   task automatic test_reset();
      bus.msg_vld = 1'b0; bus.msg_data = 32'h0; bus.msg_last = 1'b0; bus.msg_nbytes = 3'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.msg_rdy !== 1'b0 || bus.blk_vld !== 1'b0 || bus.blk_data !== 32'h0 ||
          bus.use_prec_cv !== 1'b0 || bus.pad_busy !== 1'b0 || state_dbg !== FILL) begin
         n_errors++;
         $display("FAIL reset_outputs: rdy=%0b vld=%0b data=%h prec=%0b busy=%0b st=%0d required 0/0/0/0/0/FILL",
                  bus.msg_rdy, bus.blk_vld, bus.blk_data, bus.use_prec_cv, bus.pad_busy, state_dbg);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.msg_rdy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_rdy_early: msg_rdy=%0b required 0", bus.msg_rdy);
      end
      @(negedge clk);
      n_checks++;
      if (bus.msg_rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_rdy_rise: msg_rdy=%0b required 1", bus.msg_rdy);
      end
   endtask

   task automatic test_abc();
      clear_capture();
      msg_q = '{32'h6162_6300};
      send_words(3'd3, 1'b1);
      wait_idle("abc");
      exp_q.push_back(32'h6162_6380);
      for (int i = 1; i < 15; i++) exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_0018);
      for (int i = 0; i < 16; i++) exp_prec_q.push_back(1'b0);
      n_checks++;
      if (blen_q.size() != 1 || got_q.size() != 16) begin
         n_errors++;
         $display("FAIL abc_blocks: blocks=%0d words=%0d required 1/16", blen_q.size(), got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i] || prec_q[i] !== exp_prec_q[i]) begin
            n_errors++;
            $display("FAIL abc_word%0d: data=%h prec=%0b required %h/%0b", i, got_q[i], prec_q[i], exp_q[i], exp_prec_q[i]);
         end
      end
   endtask

   task automatic test_empty();
      clear_capture();
      msg_q = '{32'hDEAD_BEEF};
      send_words(3'd0, 1'b1);
      wait_idle("empty");
      exp_q.push_back(PAD_WORD);
      for (int i = 1; i < 16; i++) exp_q.push_back(32'h0);
      for (int i = 0; i < 16; i++) exp_prec_q.push_back(1'b0);
      n_checks++;
      if (blen_q.size() != 1 || got_q.size() != 16) begin
         n_errors++;
         $display("FAIL empty_blocks: blocks=%0d words=%0d required 1/16", blen_q.size(), got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i] || prec_q[i] !== exp_prec_q[i]) begin
            n_errors++;
            $display("FAIL empty_word%0d: data=%h prec=%0b required %h/%0b", i, got_q[i], prec_q[i], exp_q[i], exp_prec_q[i]);
         end
      end
   endtask

   task automatic test_56_bytes();
      clear_capture();
      msg_q = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071};
      send_words(3'd4, 1'b1);
      wait_idle("b56");
      for (int i = 0; i < 14; i++) exp_q.push_back(msg_q[i]);
      exp_q.push_back(PAD_WORD);
      exp_q.push_back(32'h0);
      for (int i = 0; i < 15; i++) exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_01C0);
      for (int i = 0; i < 32; i++) exp_prec_q.push_back(i >= 16);
      n_checks++;
      if (blen_q.size() != 2 || blen_q[0] != 16 || blen_q[1] != 16) begin
         n_errors++;
         $display("FAIL b56_blocks: blocks=%0d words=%0d required 2x16", blen_q.size(), got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i] || prec_q[i] !== exp_prec_q[i]) begin
            n_errors++;
            $display("FAIL b56_word%0d: data=%h prec=%0b required %h/%0b", i, got_q[i], prec_q[i], exp_q[i], exp_prec_q[i]);
         end
      end
   endtask

   // 64 bytes, final nbytes=7 (treated as a full word).
   task automatic test_64_bytes();
      clear_capture();
      msg_q.delete();
      for (int i = 0; i < 16; i++) msg_q.push_back(pat(i));
      send_words(3'd7, 1'b1);
      wait_idle("b64");
      for (int i = 0; i < 16; i++) exp_q.push_back(pat(i));
      exp_q.push_back(PAD_WORD);
      for (int i = 1; i < 15; i++) exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_0200);
      for (int i = 0; i < 32; i++) exp_prec_q.push_back(i >= 16);
      n_checks++;
      if (blen_q.size() != 2 || blen_q[0] != 16 || blen_q[1] != 16) begin
         n_errors++;
         $display("FAIL b64_blocks: blocks=%0d words=%0d required 2x16", blen_q.size(), got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i] || prec_q[i] !== exp_prec_q[i]) begin
            n_errors++;
            $display("FAIL b64_word%0d: data=%h prec=%0b required %h/%0b", i, got_q[i], prec_q[i], exp_q[i], exp_prec_q[i]);
         end
      end
   endtask

   // 69 bytes: word 16 is held with msg_vld high through SEND and WAIT.
   task automatic test_back_to_back();
      clear_capture();
      msg_q.delete();
      for (int i = 0; i < 18; i++) msg_q.push_back(pat(i));
      stall_cycles = 0;
      send_words(3'd1, 1'b1);
      wait_idle("b2b");
      n_checks++;
      if (stall_cycles < 17) begin
         n_errors++;
         $display("FAIL b2b_stall: stall_cycles=%0d required >=17", stall_cycles);
      end
      for (int i = 0; i < 16; i++) exp_q.push_back(pat(i));
      exp_q.push_back(32'h4041_4243);
      exp_q.push_back(32'h4480_0000);
      for (int i = 2; i < 15; i++) exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_0228);
      for (int i = 0; i < 32; i++) exp_prec_q.push_back(i >= 16);
      n_checks++;
      if (blen_q.size() != 2 || got_q.size() != 32) begin
         n_errors++;
         $display("FAIL b2b_blocks: blocks=%0d words=%0d required 2/32", blen_q.size(), got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i] || prec_q[i] !== exp_prec_q[i]) begin
            n_errors++;
            $display("FAIL b2b_word%0d: data=%h prec=%0b required %h/%0b", i, got_q[i], prec_q[i], exp_q[i], exp_prec_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_send();
      int t = 0;
      clear_capture();
      msg_q.delete();
      for (int i = 0; i < 16; i++) msg_q.push_back(pat(i));
      send_words(3'd0, 1'b0);
      send_words(3'd0, 1'b0);
      while (!bus.blk_vld && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (bus.blk_vld !== 1'b1 || bus.use_prec_cv !== 1'b1) begin
         n_errors++;
         $display("FAIL rms_second_block: blk_vld=%0b prec=%0b required 1/1", bus.blk_vld, bus.use_prec_cv);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.blk_vld !== 1'b0 || bus.blk_data !== 32'h0 || bus.msg_rdy !== 1'b0 ||
          bus.pad_busy !== 1'b0 || bus.use_prec_cv !== 1'b0 || state_dbg !== FILL) begin
         n_errors++;
         $display("FAIL rms_async_reset: vld=%0b data=%h rdy=%0b busy=%0b prec=%0b st=%0d required 0/0/0/0/0/FILL",
                  bus.blk_vld, bus.blk_data, bus.msg_rdy, bus.pad_busy, bus.use_prec_cv, state_dbg);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_capture();
      msg_q = '{32'h6162_6300};
      send_words(3'd3, 1'b1);
      wait_idle("rms");
      exp_q.push_back(32'h6162_6380);
      for (int i = 1; i < 15; i++) exp_q.push_back(32'h0);
      exp_q.push_back(32'h0000_0018);
      for (int i = 0; i < 16; i++) exp_prec_q.push_back(1'b0);
      n_checks++;
      if (blen_q.size() != 1 || got_q.size() != 16) begin
         n_errors++;
         $display("FAIL rms_blocks: blocks=%0d words=%0d required 1/16", blen_q.size(), got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i] || prec_q[i] !== exp_prec_q[i]) begin
            n_errors++;
            $display("FAIL rms_word%0d: data=%h prec=%0b required %h/%0b", i, got_q[i], prec_q[i], exp_q[i], exp_prec_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_empty();
      test_56_bytes();
      test_64_bytes();
      test_back_to_back();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
